// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// Module      : if_fetch_unit_pkg
// Description : Shared state encodings, reset defaults and helpers for IF stage
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_HOLD  = 2'b01,
        S_DROP  = 2'b10
    } fetch_state_e;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module      : if_fetch_unit
// Description : MIPS IF stage - PC ownership, req/ack fetch, stall and redirect
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_RESET_PC,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    input  logic        IM_ACK,
    input  logic [31:0] IM_RDATA,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF,
    output logic        FetchStallF
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  hold_q, hold_d;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;
    logic         w_req;
    logic [31:0]  w_addr;
    logic         w_valid;
    logic [31:0]  w_instr;
    logic         w_fstall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_FETCH;
            pc_q       <= word_align(RESET_PC);
            req_addr_q <= word_align(RESET_PC);
            hold_q     <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        w_redirect = (JumpD | PCSrcD) & ~StallF;
        w_target   = word_align(JumpD ? PCJumpD : PCBranchD);
        w_pc_plus4 = pc_q + 32'd4;
        w_next_pc  = w_redirect ? w_target : w_pc_plus4;

        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_d     = hold_q;
        w_req      = 1'b0;
        w_addr     = pc_q;
        w_valid    = 1'b0;
        w_instr    = NOP_INSTR;
        w_fstall   = 1'b0;

        case (state_q)
            S_FETCH: begin
                w_req  = 1'b1;
                w_addr = pc_q;
                if (IM_ACK) begin
                    w_valid = 1'b1;
                    w_instr = IM_RDATA;
                    if (StallF) begin
                        hold_d  = IM_RDATA;
                        state_d = S_HOLD;
                    end else begin
                        pc_d = w_next_pc;
                    end
                end else begin
                    w_fstall = 1'b1;
                    // The unacked request must keep its address, so park it and drain it in S_DROP
                    if (w_redirect) begin
                        req_addr_d = pc_q;
                        pc_d       = w_target;
                        state_d    = S_DROP;
                    end
                end
            end
            S_HOLD: begin
                w_valid = 1'b1;
                w_instr = hold_q;
                if (!StallF) begin
                    pc_d    = w_next_pc;
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                w_req    = 1'b1;
                w_addr   = req_addr_q;
                w_fstall = ~IM_ACK;
                if (w_redirect) begin
                    pc_d = w_target;
                end
                if (IM_ACK) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset is asynchronous, so the handshake outputs are squashed combinationally too
    assign IM_REQ      = w_req & RST_N;
    assign IM_ADDR     = w_addr;
    assign ValidF      = w_valid & RST_N;
    assign InstrF      = RST_N ? w_instr : NOP_INSTR;
    assign FetchStallF = w_fstall & RST_N;
    assign PCPlus4F    = w_pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for the IF fetch unit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic        IM_ACK;
    logic [31:0] IM_RDATA;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        ValidF;
    logic        FetchStallF;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_unit dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .StallF      (StallF),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .JumpD       (JumpD),
        .PCJumpD     (PCJumpD),
        .IM_REQ      (IM_REQ),
        .IM_ADDR     (IM_ADDR),
        .IM_ACK      (IM_ACK),
        .IM_RDATA    (IM_RDATA),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .ValidF      (ValidF),
        .FetchStallF (FetchStallF)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after posedge; outputs are sampled at the negedge
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic fstall);
        check_eq({tag, ".req"},    {31'd0, IM_REQ},      {31'd0, req});
        check_eq({tag, ".addr"},   IM_ADDR,              addr);
        check_eq({tag, ".valid"},  {31'd0, ValidF},      {31'd0, valid});
        check_eq({tag, ".instr"},  InstrF,               instr);
        check_eq({tag, ".pc4"},    PCPlus4F,             pc4);
        check_eq({tag, ".fstall"}, {31'd0, FetchStallF}, {31'd0, fstall});
    endtask

    initial begin
        RST_N = 1'b0; StallF = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
        JumpD = 1'b0; PCJumpD = '0; IM_ACK = 1'b0; IM_RDATA = '0;

        // Reset state
        sample();
        check_eq("rst.req",    {31'd0, IM_REQ},      32'd0);
        check_eq("rst.valid",  {31'd0, ValidF},      32'd0);
        check_eq("rst.instr",  InstrF,               32'h0);
        check_eq("rst.fstall", {31'd0, FetchStallF}, 32'd0);
        check_eq("rst.pc4",    PCPlus4F,             32'h4);

        // Request pending, then reset asserted mid-cycle
        next_cycle();
        RST_N = 1'b1;
        sample();
        check_all("pend", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
        #1 RST_N = 1'b0;
        #1;
        check_eq("async_rst.req", {31'd0, IM_REQ}, 32'd0);
        next_cycle();
        RST_N = 1'b1;
        sample();
        check_all("post_rst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);

        // Zero-wait streaming
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            IM_ACK = 1'b1;
            IM_RDATA = 32'h11 * (i + 1);
            sample();
            check_all("stream", 1'b1, 32'(4 * i), 1'b1, 32'h11 * (i + 1), 32'(4 * i + 4), 1'b0);
        end

        // Two wait states then ack at 0xC
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            IM_ACK = 1'b0;
            IM_RDATA = 32'hFFFF_FFFF;
            sample();
            check_all("wait", 1'b1, 32'hC, 1'b0, 32'h0, 32'h10, 1'b1);
        end
        next_cycle();
        IM_ACK = 1'b1;
        IM_RDATA = 32'h44;
        sample();
        check_all("wait_ack", 1'b1, 32'hC, 1'b1, 32'h44, 32'h10, 1'b0);

        // Stall on ack at 0x10 -> hold buffer
        next_cycle();
        IM_RDATA = 32'hDEAD;
        StallF = 1'b1;
        sample();
        check_all("stall_ack", 1'b1, 32'h10, 1'b1, 32'hDEAD, 32'h14, 1'b0);
        next_cycle();
        IM_ACK = 1'b0;
        IM_RDATA = 32'h0;
        sample();
        check_eq("hold.req",   {31'd0, IM_REQ}, 32'd0);
        check_eq("hold.instr", InstrF,          32'hDEAD);
        check_eq("hold.valid", {31'd0, ValidF}, 32'd1);
        next_cycle();
        StallF = 1'b0;
        sample();
        check_eq("hold_rel.instr", InstrF, 32'hDEAD);
        next_cycle();
        sample();
        check_all("after_hold", 1'b1, 32'h14, 1'b0, 32'h0, 32'h18, 1'b1);

        // Branch while request to 0x14 is pending -> drop
        PCSrcD = 1'b1;
        PCBranchD = 32'h100;
        sample();
        next_cycle();
        PCSrcD = 1'b0;
        sample();
        check_all("drop_wait", 1'b1, 32'h14, 1'b0, 32'h0, 32'h104, 1'b1);
        next_cycle();
        IM_ACK = 1'b1;
        IM_RDATA = 32'hBAD;
        sample();
        check_all("drop_ack", 1'b1, 32'h14, 1'b0, 32'h0, 32'h104, 1'b0);

        // Jump beats branch, target aligned
        next_cycle();
        IM_RDATA = 32'h55;
        JumpD = 1'b1; PCSrcD = 1'b1; PCJumpD = 32'h203; PCBranchD = 32'h300;
        sample();
        check_all("at_100", 1'b1, 32'h100, 1'b1, 32'h55, 32'h104, 1'b0);
        next_cycle();
        IM_ACK = 1'b0;
        StallF = 1'b1;
        sample();
        check_all("jump", 1'b1, 32'h200, 1'b0, 32'h0, 32'h204, 1'b1);
        next_cycle();
        sample();
        check_eq("jump_stalled.addr", IM_ADDR, 32'h200);
        check_eq("jump_stalled.state_req", {31'd0, IM_REQ}, 32'd1);

        // Wrap from FFFF_FFFC to 0
        next_cycle();
        StallF = 1'b0; PCSrcD = 1'b0;
        IM_ACK = 1'b1; IM_RDATA = 32'h66; PCJumpD = 32'hFFFF_FFFF;
        sample();
        check_eq("jump2.addr", IM_ADDR, 32'h200);
        next_cycle();
        JumpD = 1'b0;
        IM_RDATA = 32'h77;
        sample();
        check_all("top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h77, 32'h0, 1'b0);
        next_cycle();
        sample();
        check_eq("wrap.addr", IM_ADDR, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
